// File: rtl/ioctl_download_master_pkg.sv
// Shared types and widths for the HPS-style ioctl download initiator.
package cave_ioctl_pkg;

   localparam int IOCTL_ADDR_W     = 27;
   localparam int IOCTL_DATA_W     = 16;
   localparam int IOCTL_WORD_BYTES = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      FETCH,
      WRITE,
      GAP,
      FINISH
   } ioctl_state_e;

endpackage

// File: rtl/ioctl_download_master_if.sv
// ioctl download bus as seen between the initiator (master) and the ROM loader (slave).
interface ioctl_download_master_if;
   import cave_ioctl_pkg::*;

   logic                    ioctl_download;
   logic [7:0]              ioctl_index;
   logic [IOCTL_ADDR_W-1:0] ioctl_addr;
   logic [IOCTL_DATA_W-1:0] ioctl_dout;
   logic                    ioctl_wr;
   logic                    ioctl_wait;

   modport master (
      output ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
      input  ioctl_wait
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
      output ioctl_wait
   );

endinterface

// File: rtl/ioctl_download_master.sv
// Drives an ioctl download (16-bit words) from a command plus a valid/ready word stream.
// Optional IOCTL_CHECKSUM_EN adds a 16-bit running sum of the words written.
module ioctl_download_master
   import cave_ioctl_pkg::*;
#(
   parameter int LEAD   = 2,
   parameter int WR_GAP = 4
) (
   input  logic                    clk_sys,
   input  logic                    RESET,
   input  logic                    cmd_start,
   input  logic [7:0]              cmd_index,
   input  logic [IOCTL_ADDR_W-1:0] cmd_len,
   input  logic                    cmd_abort,
   output logic                    cmd_busy,
   output logic                    cmd_done,
   output logic                    cmd_aborted,
   input  logic                    s_valid,
   input  logic [IOCTL_DATA_W-1:0] s_data,
   output logic                    s_ready,
   ioctl_download_master_if.master ioctl
`ifdef IOCTL_CHECKSUM_EN
   ,
   output logic [IOCTL_DATA_W-1:0] checksum
`endif
);

   localparam int CNT_MAX = (LEAD > WR_GAP) ? LEAD : WR_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(LEAD - 1);
   // Loaded at the handshake so the WRITE cycle plus the GAP cycles span WR_GAP-1.
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(WR_GAP - 2);

   ioctl_state_e state, state_next;

   logic [CNT_W-1:0]        cnt;
   logic [IOCTL_ADDR_W-1:0] words;
   logic [IOCTL_ADDR_W-1:0] addr;
   logic [IOCTL_DATA_W-1:0] dout;
   logic [7:0]              index;
   logic                    done;
   logic                    aborted;
   logic                    busy;
   logic                    start_accept;
   logic                    handshake;

   assign busy         = (state != IDLE);
   assign start_accept = (state == IDLE) && cmd_start && !cmd_abort;
   assign handshake    = (state == FETCH) && s_valid;

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (busy && cmd_abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_accept) state_next = START;
            START:   if (cnt == '0) state_next = (words == '0) ? FINISH : FETCH;
            FETCH:   if (s_valid) state_next = WRITE;
            WRITE:   state_next = GAP;
            GAP:     if (cnt == '0 && !ioctl.ioctl_wait)
                        state_next = (words != '0) ? FETCH : FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         cnt     <= '0;
         words   <= '0;
         addr    <= '0;
         dout    <= '0;
         index   <= '0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         done    <= (state == FINISH) && !cmd_abort;
         aborted <= busy && cmd_abort;

         if (start_accept)    cnt <= LEAD_LOAD;
         else if (handshake)  cnt <= GAP_LOAD;
         else if (cnt != '0)  cnt <= cnt - CNT_W'(1);

         if (start_accept) begin
            index <= cmd_index;
            addr  <= '0;
            words <= IOCTL_ADDR_W'(({1'b0, cmd_len} + (IOCTL_ADDR_W+1)'(1)) >> 1);
         end

         if (handshake) dout <= s_data;
         if (state == WRITE) words <= words - IOCTL_ADDR_W'(1);
         if (state == GAP && state_next == FETCH)
            addr <= addr + IOCTL_ADDR_W'(IOCTL_WORD_BYTES);
      end
   end

`ifdef IOCTL_CHECKSUM_EN
   logic [IOCTL_DATA_W-1:0] sum;

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET)             sum <= '0;
      else if (start_accept) sum <= '0;
      else if (handshake)    sum <= sum + s_data;
   end

   assign checksum = sum;
`endif

   assign cmd_busy             = busy;
   assign cmd_done             = done;
   assign cmd_aborted          = aborted;
   assign s_ready              = (state == FETCH);
   assign ioctl.ioctl_download = busy;
   assign ioctl.ioctl_index    = index;
   assign ioctl.ioctl_addr     = addr;
   assign ioctl.ioctl_dout     = dout;
   assign ioctl.ioctl_wr       = (state == WRITE);

endmodule

// File: tb/tb_ioctl_download_master.sv
// Directed self-checking bench for ioctl_download_master (LEAD=2, WR_GAP=4).
module tb_ioctl_download_master;
   import cave_ioctl_pkg::*;

   logic        clk_sys = 1'b0;
   logic        RESET;
   logic        cmd_start;
   logic [7:0]  cmd_index;
   logic [26:0] cmd_len;
   logic        cmd_abort;
   logic        cmd_busy;
   logic        cmd_done;
   logic        cmd_aborted;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
`ifdef IOCTL_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   ioctl_download_master_if bus();

   ioctl_download_master #(.LEAD(2), .WR_GAP(4)) dut (
      .clk_sys     (clk_sys),
      .RESET       (RESET),
      .cmd_start   (cmd_start),
      .cmd_index   (cmd_index),
      .cmd_len     (cmd_len),
      .cmd_abort   (cmd_abort),
      .cmd_busy    (cmd_busy),
      .cmd_done    (cmd_done),
      .cmd_aborted (cmd_aborted),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .ioctl       (bus)
`ifdef IOCTL_CHECKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   int wr_n, hs_n, done_n, done_cyc, abort_n, abort_cyc, dl_n;
   int          wr_cyc  [8];
   int          hs_cyc  [8];
   logic [26:0] wr_addr [8];
   logic [15:0] wr_dout [8];
   logic [15:0] data_tab[8];

   // One clock: the handshake is judged with the inputs about to be sampled, then outputs at the negedge.
   task automatic step();
      if (s_valid && s_ready) begin
         if (hs_n < 8) hs_cyc[hs_n] = cyc;
         hs_n++;
      end
      @(negedge clk_sys);
      cyc++;
      if (bus.ioctl_wr) begin
         if (wr_n < 8) begin
            wr_cyc[wr_n]  = cyc;
            wr_addr[wr_n] = bus.ioctl_addr;
            wr_dout[wr_n] = bus.ioctl_dout;
         end
         wr_n++;
      end
      if (cmd_done)    begin done_n++;  done_cyc  = cyc; end
      if (cmd_aborted) begin abort_n++; abort_cyc = cyc; end
      if (bus.ioctl_download) dl_n++;
      s_data = data_tab[hs_n % 8];
   endtask

   task automatic clear_log();
      wr_n = 0; hs_n = 0; done_n = 0; abort_n = 0; dl_n = 0;
      done_cyc = -1; abort_cyc = -1;
      for (int i = 0; i < 8; i++) data_tab[i] = 16'hA000 + 16'(i);
      s_data = data_tab[0];
   endtask

   task automatic start_cmd(input logic [7:0] idx, input logic [26:0] len, output int t0);
      cmd_index = idx;
      cmd_len   = len;
      cmd_start = 1'b1;
      t0        = cyc;
      step();
      cmd_start = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      step();
      step();
      tests++; if (bus.ioctl_download !== 1'b0) begin failed++; $display("[TB] FAIL reset_download got %b want 0", bus.ioctl_download); end
      tests++; if (bus.ioctl_wr !== 1'b0)       begin failed++; $display("[TB] FAIL reset_wr got %b want 0", bus.ioctl_wr); end
      tests++; if (cmd_busy !== 1'b0)           begin failed++; $display("[TB] FAIL reset_busy got %b want 0", cmd_busy); end
      tests++; if (s_ready !== 1'b0)            begin failed++; $display("[TB] FAIL reset_s_ready got %b want 0", s_ready); end
      tests++; if ({cmd_done, cmd_aborted} !== 2'b00) begin failed++; $display("[TB] FAIL reset_pulses got %b want 00", {cmd_done, cmd_aborted}); end
      tests++; if (bus.ioctl_addr !== 27'd0)    begin failed++; $display("[TB] FAIL reset_addr got %h want 0", bus.ioctl_addr); end
      tests++; if ({bus.ioctl_index, bus.ioctl_dout} !== 24'd0) begin failed++; $display("[TB] FAIL reset_index_dout got %h want 0", {bus.ioctl_index, bus.ioctl_dout}); end
      RESET = 1'b0;
      step();
      tests++; if (cmd_busy !== 1'b0) begin failed++; $display("[TB] FAIL idle_after_reset got %b want 0", cmd_busy); end
   endtask

   task automatic test_basic();
      int t0;
      clear_log();
      s_valid = 1'b1;
      start_cmd(8'h01, 27'd6, t0);
      for (int i = 0; i < 24; i++) step();
      tests++; if (wr_n !== 3) begin failed++; $display("[TB] FAIL basic_wr_count got %0d want 3", wr_n); end
      for (int i = 0; i < 3; i++) begin
         tests++; if (wr_cyc[i] !== t0 + 4 + 4*i) begin failed++; $display("[TB] FAIL basic_wr_cycle[%0d] got %0d want %0d", i, wr_cyc[i] - t0, 4 + 4*i); end
         tests++; if (wr_addr[i] !== 27'(2*i)) begin failed++; $display("[TB] FAIL basic_addr[%0d] got %h want %h", i, wr_addr[i], 2*i); end
         tests++; if (wr_dout[i] !== 16'hA000 + 16'(i)) begin failed++; $display("[TB] FAIL basic_dout[%0d] got %h want %h", i, wr_dout[i], 16'hA000 + 16'(i)); end
      end
      tests++; if (done_n !== 1 || done_cyc !== t0 + 16) begin failed++; $display("[TB] FAIL basic_done got n=%0d at %0d want n=1 at 16", done_n, done_cyc - t0); end
      tests++; if (dl_n !== 15) begin failed++; $display("[TB] FAIL basic_download_cycles got %0d want 15", dl_n); end
      tests++; if (bus.ioctl_download !== 1'b0 || cmd_busy !== 1'b0) begin failed++; $display("[TB] FAIL basic_download_after got %b want 0", bus.ioctl_download); end
      tests++; if (bus.ioctl_index !== 8'h01 || bus.ioctl_addr !== 27'd4) begin failed++; $display("[TB] FAIL basic_hold got idx=%h addr=%h want idx=01 addr=4", bus.ioctl_index, bus.ioctl_addr); end
   endtask

   task automatic test_odd_and_zero_len();
      int t0;
      clear_log();
      s_valid = 1'b1;
      start_cmd(8'h02, 27'd5, t0);
      for (int i = 0; i < 24; i++) step();
      tests++; if (wr_n !== 3) begin failed++; $display("[TB] FAIL odd_wr_count got %0d want 3", wr_n); end
      tests++; if (wr_addr[2] !== 27'd4) begin failed++; $display("[TB] FAIL odd_last_addr got %h want 4", wr_addr[2]); end
      clear_log();
      start_cmd(8'h03, 27'd0, t0);
      for (int i = 0; i < 10; i++) step();
      tests++; if (dl_n !== 3) begin failed++; $display("[TB] FAIL zero_download_cycles got %0d want 3", dl_n); end
      tests++; if (wr_n !== 0) begin failed++; $display("[TB] FAIL zero_wr_count got %0d want 0", wr_n); end
      tests++; if (done_n !== 1 || done_cyc !== t0 + 4) begin failed++; $display("[TB] FAIL zero_done got n=%0d at %0d want n=1 at 4", done_n, done_cyc - t0); end
   endtask

   task automatic test_wait();
      int t0;
      int wait_n = 0;
      clear_log();
      s_valid = 1'b1;
      start_cmd(8'h04, 27'd4, t0);
      for (int i = 0; i < 30; i++) begin
         step();
         if (wr_n == 1 && wait_n < 10) begin
            bus.ioctl_wait = 1'b1;
            wait_n++;
         end else begin
            bus.ioctl_wait = 1'b0;
         end
      end
      tests++; if (wr_n !== 2) begin failed++; $display("[TB] FAIL wait_wr_count got %0d want 2", wr_n); end
      tests++; if (wr_cyc[1] !== t0 + 16) begin failed++; $display("[TB] FAIL wait_second_wr got %0d want 16", wr_cyc[1] - t0); end
      tests++; if (wr_addr[1] !== 27'd2) begin failed++; $display("[TB] FAIL wait_second_addr got %h want 2", wr_addr[1]); end
   endtask

   task automatic test_valid_gaps();
      int t0;
      clear_log();
      s_valid = 1'b0;
      start_cmd(8'h05, 27'd8, t0);
      for (int i = 0; i < 45; i++) begin
         step();
         s_valid = (cyc % 3 == 0);
      end
      s_valid = 1'b0;
      tests++; if (wr_n !== 4 || hs_n !== 4) begin failed++; $display("[TB] FAIL gaps_counts got wr=%0d hs=%0d want 4/4", wr_n, hs_n); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (wr_cyc[i] !== hs_cyc[i] + 1) begin failed++; $display("[TB] FAIL gaps_wr_after_hs[%0d] got %0d want %0d", i, wr_cyc[i], hs_cyc[i] + 1); end
         tests++; if (wr_dout[i] !== 16'hA000 + 16'(i) || wr_addr[i] !== 27'(2*i)) begin failed++; $display("[TB] FAIL gaps_word[%0d] got %h@%h want %h@%h", i, wr_dout[i], wr_addr[i], 16'hA000 + 16'(i), 2*i); end
      end
      tests++; if (done_n !== 1) begin failed++; $display("[TB] FAIL gaps_done got %0d want 1", done_n); end
   endtask

   task automatic test_abort();
      int t0;
      clear_log();
      s_valid = 1'b1;
      start_cmd(8'h22, 27'd8, t0);
      for (int i = 0; i < 20; i++) begin
         step();
         cmd_start = (cyc - t0 == 6);
         cmd_index = (cyc - t0 == 6) ? 8'h55 : 8'h22;
         cmd_abort = (cyc - t0 == 9);
      end
      tests++; if (abort_n !== 1 || abort_cyc !== t0 + 10) begin failed++; $display("[TB] FAIL abort_pulse got n=%0d at %0d want n=1 at 10", abort_n, abort_cyc - t0); end
      tests++; if (dl_n !== 9) begin failed++; $display("[TB] FAIL abort_download_cycles got %0d want 9", dl_n); end
      tests++; if (done_n !== 0) begin failed++; $display("[TB] FAIL abort_no_done got %0d want 0", done_n); end
      tests++; if (wr_n !== 2 || wr_cyc[1] !== t0 + 8) begin failed++; $display("[TB] FAIL abort_writes got n=%0d 2nd at %0d want n=2 at 8", wr_n, wr_cyc[1] - t0); end
      tests++; if (bus.ioctl_index !== 8'h22) begin failed++; $display("[TB] FAIL busy_start_ignored got idx=%h want 22", bus.ioctl_index); end
   endtask

   task automatic test_reset_mid();
      int t0;
      clear_log();
      s_valid = 1'b0;
      start_cmd(8'h33, 27'd4, t0);
      for (int i = 0; i < 4; i++) step();
      tests++; if (s_ready !== 1'b1 || bus.ioctl_download !== 1'b1) begin failed++; $display("[TB] FAIL mid_in_fetch got ready=%b dl=%b want 1/1", s_ready, bus.ioctl_download); end
      #1 RESET = 1'b1;
      #1;
      tests++; if (bus.ioctl_download !== 1'b0 || cmd_busy !== 1'b0 || s_ready !== 1'b0) begin failed++; $display("[TB] FAIL mid_reset_ctrl got dl=%b busy=%b ready=%b want 0", bus.ioctl_download, cmd_busy, s_ready); end
      tests++; if (bus.ioctl_index !== 8'h00 || bus.ioctl_wr !== 1'b0) begin failed++; $display("[TB] FAIL mid_reset_bus got idx=%h wr=%b want 0", bus.ioctl_index, bus.ioctl_wr); end
      step();
      RESET = 1'b0;
      step();
      tests++; if (done_n !== 0 || abort_n !== 0) begin failed++; $display("[TB] FAIL mid_reset_no_pulse got done=%0d abort=%0d want 0", done_n, abort_n); end
   endtask

`ifdef IOCTL_CHECKSUM_EN
   task automatic test_checksum();
      int t0;
      clear_log();
      data_tab[0] = 16'hFFFF;
      data_tab[1] = 16'h0002;
      s_data      = data_tab[0];
      s_valid     = 1'b1;
      start_cmd(8'h06, 27'd4, t0);
      for (int i = 0; i < 20; i++) step();
      tests++; if (done_n !== 1 || checksum !== 16'h0001) begin failed++; $display("[TB] FAIL checksum got %h (done=%0d) want 0001", checksum, done_n); end
   endtask
`endif

   initial begin
      RESET = 1'b1;
      cmd_start = 1'b0; cmd_index = 8'h00; cmd_len = 27'd0; cmd_abort = 1'b0;
      s_valid = 1'b0; s_data = 16'h0000;
      bus.ioctl_wait = 1'b0;
      clear_log();
      test_reset();
      test_basic();
      test_odd_and_zero_len();
      test_wait();
      test_valid_gaps();
      test_abort();
      test_reset_mid();
`ifdef IOCTL_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
